// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-memory responder with CPU port, host load/dump engine and access counters
module data_mem_responder #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CEN,
  input  logic              WEN,
  input  logic              OEN,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] Q,
  input  logic              load_start,
  input  logic              dump_start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DUMP} state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state;
  logic [ADDR_W:0]   ptr;

  logic              cpu_rd;
  logic              cpu_wr;
  logic              load_fire;
  logic              dump_fire;
  logic [ADDR_W-1:0] ptr_idx;
  logic [ADDR_W-1:0] nxt_idx;
  logic [DATA_W-1:0] nxt_word;
  logic [DATA_W-1:0] first_word;

  assign cpu_rd    = !CEN && WEN;
  assign cpu_wr    = !CEN && !WEN;
  // The CPU owns the array whenever it is selected, so loads stall on CEN=0.
  assign in_ready  = (state == LOAD) && CEN;
  assign busy      = (state != IDLE);
  assign load_fire = in_valid && in_ready;
  assign dump_fire = out_valid && out_ready;
  assign ptr_idx   = ptr[ADDR_W-1:0];
  assign nxt_idx   = ptr_idx + 1'b1;

  // Prefetched dump words see a same-cycle CPU write to the same address.
  assign nxt_word   = (cpu_wr && (A == nxt_idx)) ? D : mem[nxt_idx];
  assign first_word = (cpu_wr && (A == '0)) ? D : mem[0];

  // CPU read data appears in the same cycle; writes and disabled outputs return zero.
  assign Q = (cpu_rd && !OEN) ? mem[A] : '0;

  // Memory array: CPU writes and host load writes never collide because loads need CEN=1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (cpu_wr)    mem[A]       <= D;
      if (load_fire) mem[ptr_idx] <= in_data;
    end
  end

  // Load/dump sequencer with registered out_valid, out_data and done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            state <= LOAD;
            ptr   <= '0;
          end else if (dump_start) begin
            state     <= DUMP;
            ptr       <= '0;
            out_valid <= 1'b1;
            out_data  <= first_word;
          end
        end
        LOAD: begin
          if (load_fire) begin
            ptr <= ptr + 1'b1;
            if (ptr == LAST) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        DUMP: begin
          if (dump_fire) begin
            if (ptr == LAST) begin
              out_valid <= 1'b0;
              state     <= IDLE;
              done      <= 1'b1;
            end else begin
              ptr      <= ptr + 1'b1;
              out_data <= nxt_word;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating CPU access counters; host transfers are not counted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (cpu_rd && (rd_cnt != '1)) rd_cnt <= rd_cnt + 1'b1;
      if (cpu_wr && (wr_cnt != '1)) wr_cnt <= wr_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        CEN, WEN, OEN;
  logic [6:0]  A;
  logic [31:0] D;
  logic [31:0] Q;
  logic        load_start, dump_start, in_valid, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid, busy, done;
  logic [31:0] out_data;
  logic [15:0] rd_cnt, wr_cnt;

  logic [31:0] s_Q, s_out_data;
  logic        s_in_ready, s_out_valid, s_busy, s_done;
  logic [2:0]  s_rd_cnt, s_wr_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  data_mem_responder dut (
    .clk(clk), .rst_n(rst_n), .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .D(D), .Q(Q),
    .load_start(load_start), .dump_start(dump_start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  // Narrow-counter instance so saturation is reachable in a few cycles.
  data_mem_responder #(.ADDR_W(7), .DATA_W(32), .CNT_W(3)) sat (
    .clk(clk), .rst_n(rst_n), .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .D(D), .Q(s_Q),
    .load_start(load_start), .dump_start(dump_start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(s_in_ready), .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(out_ready),
    .busy(s_busy), .done(s_done), .rd_cnt(s_rd_cnt), .wr_cnt(s_wr_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; CEN = 1'b1; WEN = 1'b1; OEN = 1'b1; A = '0; D = '0;
    load_start = 1'b0; dump_start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick; tick;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (out_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_valid_done got=%b%b exp=00", out_valid, done); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (rd_cnt !== 16'h0 || wr_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got=%h/%h exp=0/0", rd_cnt, wr_cnt); end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_cpu_rw;
    CEN = 1'b0; WEN = 1'b0; OEN = 1'b0; A = 7'd5; D = 32'hDEADBEEF;
    #1;
    checks++; if (Q !== 32'h0) begin errors++; $display("FAIL write_cycle_q got=%h exp=0", Q); end
    tick;
    WEN = 1'b1;
    #1;
    checks++; if (Q !== 32'hDEADBEEF) begin errors++; $display("FAIL read_q got=%h exp=deadbeef", Q); end
    OEN = 1'b1;
    #1;
    checks++; if (Q !== 32'h0) begin errors++; $display("FAIL read_oen_q got=%h exp=0", Q); end
    tick;
    CEN = 1'b1; OEN = 1'b1;
    checks++; if (wr_cnt !== 16'd1 || rd_cnt !== 16'd1) begin errors++; $display("FAIL cpu_cnt got=%0d/%0d exp=1/1", wr_cnt, rd_cnt); end
  endtask

  task automatic test_load;
    int k;
    bit exp_rdy;
    k = 0;
    load_start = 1'b1; tick; load_start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_busy got=%b exp=1", busy); end
    for (int c = 0; c < 300 && k < 128; c++) begin
      exp_rdy = !(c >= 10 && c <= 12);
      CEN = exp_rdy; WEN = 1'b1; OEN = 1'b1; A = '0;
      in_valid = 1'b1; in_data = 32'(k * 3);
      #1;
      checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL load_in_ready c=%0d got=%b exp=%b", c, in_ready, exp_rdy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL load_done_early c=%0d got=%b exp=0", c, done); end
      tick;
      if (exp_rdy) k++;
    end
    in_valid = 1'b0; CEN = 1'b1;
    checks++; if (k !== 128) begin errors++; $display("FAIL load_timeout got=%0d exp=128", k); end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL load_end done/busy got=%b/%b exp=1/0", done, busy); end
    tick;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL load_done_pulse got=%b exp=0", done); end
    foreach (k_list[i]) begin
      CEN = 1'b0; WEN = 1'b1; OEN = 1'b0; A = 7'(k_list[i]);
      #1;
      checks++; if (Q !== 32'(k_list[i] * 3)) begin errors++; $display("FAIL load_mem a=%0d got=%h exp=%h", k_list[i], Q, 32'(k_list[i] * 3)); end
      tick;
    end
    CEN = 1'b1; OEN = 1'b1;
  endtask

  int k_list[5] = '{0, 10, 11, 12, 127};

  task automatic test_dump;
    int idx;
    idx = 0;
    dump_start = 1'b1; tick; dump_start = 1'b0;
    for (int c = 0; c < 400 && idx < 128; c++) begin
      out_ready = (c % 2 == 0);
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dump_valid idx=%0d got=%b exp=1", idx, out_valid); end
      checks++; if (out_data !== 32'(idx * 3)) begin errors++; $display("FAIL dump_data idx=%0d got=%h exp=%h", idx, out_data, 32'(idx * 3)); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL dump_done_early idx=%0d got=%b exp=0", idx, done); end
      tick;
      if (c % 2 == 0) idx++;
    end
    out_ready = 1'b0;
    checks++; if (idx !== 128) begin errors++; $display("FAIL dump_timeout got=%0d exp=128", idx); end
    checks++; if (out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL dump_end valid/done/busy got=%b/%b/%b exp=0/1/0", out_valid, done, busy); end
    tick;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL dump_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_forward;
    dump_start = 1'b1; tick; dump_start = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) tick;
    out_ready = 1'b0;
    checks++; if (out_data !== 32'd27) begin errors++; $display("FAIL fwd_word9 got=%h exp=1b", out_data); end
    out_ready = 1'b1; CEN = 1'b0; WEN = 1'b0; A = 7'd10; D = 32'h55;
    tick;
    out_ready = 1'b0; CEN = 1'b1;
    checks++; if (out_data !== 32'h55) begin errors++; $display("FAIL fwd_word10 got=%h exp=55", out_data); end
    CEN = 1'b0; WEN = 1'b0; A = 7'd10; D = 32'h99;
    tick;
    CEN = 1'b1;
    checks++; if (out_data !== 32'h55) begin errors++; $display("FAIL fwd_hold got=%h exp=55", out_data); end
    out_ready = 1'b1;
    tick;
    checks++; if (out_data !== 32'd33) begin errors++; $display("FAIL fwd_word11 got=%h exp=21", out_data); end
    for (int c = 0; c < 200 && out_valid; c++) tick;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL fwd_end valid/done got=%b/%b exp=0/1", out_valid, done); end
    CEN = 1'b0; WEN = 1'b1; OEN = 1'b0; A = 7'd10;
    #1;
    checks++; if (Q !== 32'h99) begin errors++; $display("FAIL fwd_mem10 got=%h exp=99", Q); end
    tick;
    CEN = 1'b1; OEN = 1'b1;
  endtask

  task automatic test_start_priority;
    load_start = 1'b1; dump_start = 1'b1; tick; load_start = 1'b0; dump_start = 1'b0;
    checks++; if (busy !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL both_start busy/rdy/valid got=%b/%b/%b exp=1/1/0", busy, in_ready, out_valid); end
    dump_start = 1'b1; tick; dump_start = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL dump_in_load rdy/valid got=%b/%b exp=1/0", in_ready, out_valid); end
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data = 32'(100 + k);
      tick;
    end
    in_valid = 1'b0;
    CEN = 1'b0; WEN = 1'b1; OEN = 1'b0; A = 7'd2;
    #1;
    checks++; if (Q !== 32'd102) begin errors++; $display("FAIL partial_load_q got=%h exp=66", Q); end
    tick;
    CEN = 1'b1; OEN = 1'b1;
  endtask

  task automatic test_reset_mid_load;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_load_busy got=%b exp=1", busy); end
    rst_n = 1'b0; tick; rst_n = 1'b1;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid busy/rdy/valid got=%b/%b/%b exp=0/0/0", busy, in_ready, out_valid); end
    checks++; if (rd_cnt !== 16'h0 || wr_cnt !== 16'h0) begin errors++; $display("FAIL rst_mid_cnt got=%h/%h exp=0/0", rd_cnt, wr_cnt); end
    for (int a = 0; a < 128; a += 9) begin
      CEN = 1'b0; WEN = 1'b1; OEN = 1'b0; A = 7'(a);
      #1;
      checks++; if (Q !== 32'h0) begin errors++; $display("FAIL rst_mid_mem a=%0d got=%h exp=0", a, Q); end
      tick;
    end
    CEN = 1'b1; OEN = 1'b1;
  endtask

  task automatic test_saturation;
    rst_n = 1'b0; tick; rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      CEN = 1'b0; WEN = 1'b0; A = 7'(i); D = 32'(i);
      tick;
    end
    CEN = 1'b1;
    checks++; if (wr_cnt !== 16'd9) begin errors++; $display("FAIL wr_cnt_wide got=%0d exp=9", wr_cnt); end
    checks++; if (s_wr_cnt !== 3'd7 || s_rd_cnt !== 3'd0) begin errors++; $display("FAIL wr_cnt_sat got=%0d/%0d exp=7/0", s_wr_cnt, s_rd_cnt); end
    for (int i = 0; i < 9; i++) begin
      CEN = 1'b0; WEN = 1'b1; OEN = 1'b1; A = 7'(i);
      tick;
    end
    CEN = 1'b1;
    checks++; if (rd_cnt !== 16'd9) begin errors++; $display("FAIL rd_cnt_wide got=%0d exp=9", rd_cnt); end
    checks++; if (s_rd_cnt !== 3'd7 || s_wr_cnt !== 3'd7) begin errors++; $display("FAIL rd_cnt_sat got=%0d/%0d exp=7/7", s_rd_cnt, s_wr_cnt); end
    tick;
    checks++; if (s_rd_cnt !== 3'd7 || rd_cnt !== 16'd9) begin errors++; $display("FAIL cnt_idle_hold got=%0d/%0d exp=7/9", s_rd_cnt, rd_cnt); end
  endtask

  initial begin
    test_reset;
    test_cpu_rw;
    test_load;
    test_dump;
    test_forward;
    test_start_priority;
    test_reset_mid_load;
    test_saturation;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
